// File: rtl/inst_assembler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_assembler : RV32I field encoder with range checks, feeding an
// auto-incrementing instruction-memory write port.          rev 1.0
// ---------------------------------------------------------------------------
module inst_assembler #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err,
  output logic [2:0]        err_code,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_OPCODE = 3'd1;
  localparam logic [2:0] ERR_RANGE  = 3'd2;
  localparam logic [2:0] ERR_ALIGN  = 3'd3;
  localparam logic [2:0] ERR_SHIFT  = 3'd4;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic        s1_valid;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imm;

  logic        s2_valid;
  logic        s2_drop;

  logic [31:0] enc_word;
  logic [2:0]  enc_code;
  logic        fits_i;
  logic        fits_b;
  logic        fits_j;
  logic        is_shift;

  logic        commit;
  logic        s2_free;
  logic        advance;
  logic        accept;

  assign fits_i   = ($signed(s1_imm) >= -32'sd2048) && ($signed(s1_imm) <= 32'sd2047);
  assign fits_b   = ($signed(s1_imm) >= -32'sd4096) && ($signed(s1_imm) <= 32'sd4094);
  assign fits_j   = ($signed(s1_imm) >= -32'sd1048576) && ($signed(s1_imm) <= 32'sd1048574);
  assign is_shift = (s1_funct3 == 3'b001) || (s1_funct3 == 3'b101);

  // Checks are ordered opcode, funct7, alignment, range; the first hit wins.
  always_comb begin
    enc_word = '0;
    enc_code = ERR_NONE;
    case (s1_opcode)
      OP_R: begin
        enc_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      end
      OP_LOAD, OP_IMM, OP_JALR: begin
        if ((s1_opcode == OP_IMM) && is_shift) begin
          enc_word = {s1_funct7, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
          if (!((s1_funct7 == 7'b0000000) ||
                ((s1_funct7 == 7'b0100000) && (s1_funct3 == 3'b101)))) begin
            enc_code = ERR_SHIFT;
          end else if (s1_imm[31:5] != '0) begin
            enc_code = ERR_RANGE;
          end
        end else begin
          enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
          if (!fits_i) enc_code = ERR_RANGE;
        end
      end
      OP_STORE: begin
        enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
        if (!fits_i) enc_code = ERR_RANGE;
      end
      OP_BRANCH: begin
        enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                    s1_imm[4:1], s1_imm[11], s1_opcode};
        if (s1_imm[0])    enc_code = ERR_ALIGN;
        else if (!fits_b) enc_code = ERR_RANGE;
      end
      OP_LUI, OP_AUIPC: begin
        enc_word = {s1_imm[31:12], s1_rd, s1_opcode};
        if (s1_imm[11:0] != '0) enc_code = ERR_RANGE;
      end
      OP_JAL: begin
        enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
        if (s1_imm[0])    enc_code = ERR_ALIGN;
        else if (!fits_j) enc_code = ERR_RANGE;
      end
      default: enc_code = ERR_OPCODE;
    endcase
  end

  // A dropped word never requests a write, so it frees stage 2 after one cycle.
  assign wr_en    = s2_valid && !s2_drop && !full;
  assign commit   = wr_en && wr_ready;
  assign s2_free  = !s2_valid || s2_drop || commit;
  assign advance  = s1_valid && s2_free;
  assign in_ready = !full && !clear && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_imm    <= '0;
      s2_valid  <= 1'b0;
      s2_drop   <= 1'b0;
      wr_data   <= '0;
      wr_addr   <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      full      <= 1'b0;
      count     <= '0;
    end else if (clear) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_drop   <= 1'b0;
      wr_addr   <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      full      <= 1'b0;
      count     <= '0;
    end else begin
      if (accept) begin
        s1_opcode <= opcode;
        s1_rd     <= rd;
        s1_rs1    <= rs1;
        s1_rs2    <= rs2;
        s1_funct3 <= funct3;
        s1_funct7 <= funct7;
        s1_imm    <= imm;
      end
      s1_valid <= accept || (s1_valid && !advance);

      if (advance) begin
        s2_valid <= 1'b1;
        s2_drop  <= (enc_code != ERR_NONE);
        if (enc_code == ERR_NONE) begin
          wr_data <= enc_word;
        end else begin
          err <= 1'b1;
          if (err_code == ERR_NONE) err_code <= enc_code;
        end
      end else if (s2_free) begin
        s2_valid <= 1'b0;
        s2_drop  <= 1'b0;
      end

      // Address wraps to zero on the last slot and is then frozen by full.
      if (commit) begin
        count   <= count + CNT_ONE;
        wr_addr <= wr_addr + 1'b1;
        if (&wr_addr) full <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_assembler.sv
`default_nettype none
// tb_inst_assembler : directed and randomized checks against a field-level encoder model.
module tb_inst_assembler;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    opcode = '0;
  logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [31:0]   imm = '0;
  logic          wr_en;
  logic          wr_ready = 1'b1;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          err;
  logic [2:0]    err_code;
  logic          full;
  logic [AW:0]   count;

  inst_assembler #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .err(err), .err_code(err_code), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic rand_ready = 1'b0;

  logic [AW+31:0] got_q[$];
  int             got_cyc[$];
  logic [AW+31:0] exp_q[$];
  logic [AW-1:0]  m_addr = '0;
  int             m_count = 0;
  logic           m_err = 1'b0;
  logic [2:0]     m_code = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rand_ready) wr_ready = ($urandom % 4) != 0;

  // Commit monitor: values present just after the falling edge hold through the next rise.
  always @(negedge clk) begin
    #1;
    if (rst_n && !clear && wr_en && wr_ready) begin
      got_q.push_back({wr_addr, wr_data});
      got_cyc.push_back(cyc);
    end
  end

  // Reference encoder built from the field layout tables using plain integer arithmetic.
  function automatic void ref_enc(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                  input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] im, output logic [2:0] code, output logic [31:0] w);
    longint v, u, lop, ld, ls1, ls2, lf3, lf7, r;
    v = $signed(im);
    lop = op; ld = d; ls1 = s1; ls2 = s2; lf3 = f3; lf7 = f7;
    code = 0; r = 0;
    case (op)
      7'h33: r = lf7 * (1 << 25) + ls2 * (1 << 20) + ls1 * (1 << 15) + lf3 * (1 << 12) + ld * 128 + lop;
      7'h03, 7'h13, 7'h67: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          if (!(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5))) code = 4;
          else if (v < 0 || v > 31) code = 2;
          r = lf7 * (1 << 25) + (v & 31) * (1 << 20) + ls1 * (1 << 15) + lf3 * (1 << 12) + ld * 128 + lop;
        end else begin
          if (v < -2048 || v > 2047) code = 2;
          r = (v & 4095) * (1 << 20) + ls1 * (1 << 15) + lf3 * (1 << 12) + ld * 128 + lop;
        end
      end
      7'h23: begin
        if (v < -2048 || v > 2047) code = 2;
        r = ((v >> 5) & 127) * (1 << 25) + ls2 * (1 << 20) + ls1 * (1 << 15) + lf3 * (1 << 12)
            + (v & 31) * 128 + lop;
      end
      7'h63: begin
        if ((v & 1) != 0) code = 3;
        else if (v < -4096 || v > 4094) code = 2;
        u = v & 64'h1FFF;
        r = ((u >> 12) & 1) * (64'd1 << 31) + ((u >> 5) & 63) * (1 << 25) + ls2 * (1 << 20)
            + ls1 * (1 << 15) + lf3 * (1 << 12) + ((u >> 1) & 15) * 256 + ((u >> 11) & 1) * 128 + lop;
      end
      7'h37, 7'h17: begin
        if ((v & 4095) != 0) code = 2;
        r = (v & 64'hFFFFF000) + ld * 128 + lop;
      end
      7'h6F: begin
        if ((v & 1) != 0) code = 3;
        else if (v < -(64'sd1 << 20) || v > (64'sd1 << 20) - 2) code = 2;
        u = v & 64'h1FFFFF;
        r = ((u >> 20) & 1) * (64'd1 << 31) + ((u >> 1) & 1023) * (1 << 21) + ((u >> 11) & 1) * (1 << 20)
            + ((u >> 12) & 255) * (1 << 12) + ld * 128 + lop;
      end
      default: code = 1;
    endcase
    w = r[31:0];
  endfunction

  task automatic model_add(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] im);
    logic [2:0] c;
    logic [31:0] w;
    ref_enc(op, d, s1, s2, f3, f7, im, c, w);
    if (c == 0) begin
      exp_q.push_back({m_addr, w});
      m_addr++;
      m_count++;
    end else begin
      m_err = 1'b1;
      if (m_code == 0) m_code = c;
    end
  endtask

  // Present a field set and return once in_ready is seen; it is accepted at the next rising edge.
  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im);
    int b;
    model_add(op, d, s1, s2, f3, f7, im);
    @(negedge clk);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    #1;
    b = 0;
    while (!in_ready && b < 60) begin
      @(negedge clk); #1; b++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, b);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic flush();
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    m_addr = '0; m_count = 0; m_err = 1'b0; m_code = '0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({in_ready, wr_en, wr_addr, wr_data, err, err_code, full, count} !==
        {1'b1, 1'b0, {AW{1'b0}}, 32'h0, 1'b0, 3'd0, 1'b0, {(AW+1){1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%0b wen=%0b addr=%0d data=%h err=%0b code=%0d full=%0b cnt=%0d, required 1 0 0 0 0 0 0 0",
               in_ready, wr_en, wr_addr, wr_data, err, err_code, full, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    flush();
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    idle(); #1;
    n_tests++;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL addi_early: wr_en=%0b, required 0", wr_en); end
    @(negedge clk); #1;
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, {AW{1'b0}}, 32'hFFF00093}) begin
      n_fail++;
      $display("FAIL addi_word: wr_en=%0b addr=%0d data=%h, required 1 0 fff00093", wr_en, wr_addr, wr_data);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({wr_en, count} !== {1'b0, 3'd1}) begin
      n_fail++; $display("FAIL addi_count: wr_en=%0b count=%0d, required 0 1", wr_en, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ew[3] = '{32'h0020A423, 32'hFE000EE3, 32'h001000EF};
    flush();
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
    idle();
    repeat (4) @(negedge clk);
    n_tests++;
    if (got_q.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: %0d writes, required 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (got_q[i] !== {i[AW-1:0], ew[i]}) begin
          n_fail++; $display("FAIL b2b_word%0d: got %h, required %h", i, got_q[i], {i[AW-1:0], ew[i]});
        end
      end
      n_tests++;
      if (got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1) begin
        n_fail++; $display("FAIL b2b_spacing: cycles %0d %0d %0d, required consecutive", got_cyc[0], got_cyc[1], got_cyc[2]);
      end
    end
  endtask

  task automatic test_stall();
    logic [AW+31:0] held;
    flush();
    wr_ready = 1'b0;
    send(7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd100);
    send(7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'd0);
    model_add(7'h03, 5'd8, 5'd9, 5'd0, 3'd2, 7'd0, 32'hFFFFF800);
    @(negedge clk);
    opcode = 7'h03; rd = 5'd8; rs1 = 5'd9; rs2 = 5'd0; funct3 = 3'd2; funct7 = 7'd0; imm = 32'hFFFFF800;
    in_valid = 1'b1;
    #1;
    held = {wr_addr, wr_data};
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({in_ready, wr_en, wr_addr, wr_data} !== {1'b0, 1'b1, held}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: rdy=%0b wen=%0b word=%h, required 0 1 %h", k, in_ready, wr_en, {wr_addr, wr_data}, held);
      end
      @(negedge clk); #1;
    end
    @(negedge clk);
    wr_ready = 1'b1;
    #1;
    while (!in_ready) begin @(negedge clk); #1; end
    idle();
    repeat (4) @(negedge clk);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL stall_count: %0d writes, required %0d", got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL stall_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
  endtask

  task automatic test_errors();
    flush();
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    send(7'h13, 5'd5, 5'd5, 5'd0, 3'd0, 7'd0, 32'd7);
    idle();
    repeat (4) @(negedge clk); #1;
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== {{AW{1'b0}}, 32'h00728293}) begin
      n_fail++; $display("FAIL err_write: %0d writes first=%h, required 1 write of 0_00728293", got_q.size(), got_q.size() ? got_q[0] : '0);
    end
    n_tests++;
    if ({err, err_code, count} !== {1'b1, 3'd2, 3'd1}) begin
      n_fail++; $display("FAIL err_state: err=%0b code=%0d count=%0d, required 1 2 1", err, err_code, count);
    end
  endtask

  task automatic test_invalid();
    logic [6:0] ops[3] = '{7'h7F, 7'h13, 7'h37};
    logic [2:0] f3s[3] = '{3'd0, 3'd1, 3'd0};
    logic [6:0] f7s[3] = '{7'd0, 7'h20, 7'd0};
    logic [31:0] ims[3] = '{32'd0, 32'd3, 32'h12345001};
    logic [2:0] codes[3] = '{3'd1, 3'd4, 3'd2};
    for (int i = 0; i < 3; i++) begin
      flush();
      send(ops[i], 5'd1, 5'd2, 5'd3, f3s[i], f7s[i], ims[i]);
      idle();
      repeat (3) @(negedge clk); #1;
      n_tests++;
      if ({err, err_code, got_q.size() == 0} !== {1'b1, codes[i], 1'b1}) begin
        n_fail++; $display("FAIL invalid%0d: err=%0b code=%0d writes=%0d, required 1 %0d 0", i, err, err_code, got_q.size(), codes[i]);
      end
    end
  endtask

  task automatic test_full_clear();
    flush();
    send(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int i = 0; i < 4; i++) send(7'h13, i[4:0], 5'd0, 5'd0, 3'd0, 7'd0, i);
    idle();
    repeat (4) @(negedge clk); #1;
    n_tests++;
    if ({full, in_ready, count, err} !== {1'b1, 1'b0, 3'd4, 1'b1}) begin
      n_fail++; $display("FAIL full_state: full=%0b rdy=%0b count=%0d err=%0b, required 1 0 4 1", full, in_ready, count, err);
    end
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready: in_ready=%0b, required 0", in_ready); end
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++;
    if ({full, wr_addr, count, err, err_code, in_ready} !== {1'b0, {AW{1'b0}}, 3'd0, 1'b0, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL clear_state: full=%0b addr=%0d count=%0d err=%0b code=%0d rdy=%0b, required 0 0 0 0 0 1",
                         full, wr_addr, count, err, err_code, in_ready);
    end
  endtask

  task automatic test_async_reset();
    flush();
    wr_ready = 1'b0;
    send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    idle();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({wr_en, count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL async_reset: wr_en=%0b count=%0d rdy=%0b, required 0 0 1", wr_en, count, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; wr_ready = 1'b1;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    m_addr = '0; m_count = 0; m_err = 1'b0; m_code = '0;
    send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    idle();
    repeat (3) @(negedge clk);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== {{AW{1'b0}}, 32'h00900113}) begin
      n_fail++; $display("FAIL post_reset_write: %0d writes, required 1 of 0_00900113", got_q.size());
    end
  endtask

  task automatic test_random();
    logic [6:0] op_tab[11] = '{7'h33, 7'h03, 7'h13, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h5B};
    int edge_tab[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 31, 32, 0, -1,
                         1048574, -1048576, 1048576};
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [31:0] im;
    int n;
    for (int it = 0; it < 25; it++) begin
      flush();
      rand_ready = 1'b1;
      n = $urandom_range(1, 7);
      for (int j = 0; j < n && m_count < 4; j++) begin
        op = op_tab[$urandom_range(0, 10)];
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
          0: f7 = 7'h00;
          1: f7 = 7'h20;
          default: f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 4))
          0: im = 32'($signed($urandom_range(0, 64)) - 32);
          1: im = $urandom;
          2: im = edge_tab[$urandom_range(0, 13)];
          3: im = $urandom & 32'hFFFFF000;
          default: im = 32'($signed($urandom_range(0, 8190)) - 4096);
        endcase
        send(op, 5'($urandom), 5'($urandom), 5'($urandom), f3, f7, im);
      end
      idle();
      rand_ready = 1'b0;
      wr_ready = 1'b1;
      repeat (5) @(negedge clk); #1;
      n_tests++;
      if (got_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_count: %0d writes, required %0d", it, got_q.size(), exp_q.size());
      end else
        for (int i = 0; i < exp_q.size(); i++) begin
          n_tests++;
          if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL rand%0d_word%0d: got %h, required %h", it, i, got_q[i], exp_q[i]);
          end
        end
      n_tests++;
      if ({err, err_code, count, full} !== {m_err, m_code, 3'(m_count), m_count == 4}) begin
        n_fail++; $display("FAIL rand%0d_state: err=%0b code=%0d count=%0d full=%0b, required %0b %0d %0d %0b",
                           it, err, err_code, count, full, m_err, m_code, m_count, m_count == 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_errors();
    test_invalid();
    test_full_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
